// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock circular-buffer FIFO with empty/full/count status
// Revision  : 1.0
// ============================================================================
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_WIDTH-1:0]  fifo_cnt
);

    localparam int                   PTR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] C_DEPTH   = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);
    localparam logic [PTR_WIDTH-1:0] C_PTR_ONE = PTR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_data_out;

    logic w_rd_acc;
    logic w_wr_acc;

    assign empty    = (r_cnt == '0);
    assign full     = (r_cnt == C_DEPTH);
    assign fifo_cnt = r_cnt;
    assign data_out = r_data_out;

    // A read frees a slot on the same edge, so a full FIFO still takes a write
    // when a read is also accepted.
    assign w_rd_acc = rd & ~empty;
    assign w_wr_acc = wr & (~full | w_rd_acc);

    always_ff @(posedge clk) begin
        if (w_wr_acc && rst) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_data_out <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr   <= r_rd_ptr + C_PTR_ONE;
                r_data_out <= r_mem[r_rd_ptr];
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_cnt <= r_cnt + C_CNT_ONE;
                2'b01:   r_cnt <= r_cnt - C_CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// tb_sync_fifo : directed bench with a queue-based reference model
// Revision     : 1.0
// ============================================================================
module tb_sync_fifo;

    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 8;
    localparam int CNT_WIDTH  = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [DATA_WIDTH-1:0] data_in = '0;
    logic                  wr = 1'b0;
    logic                  rd = 1'b0;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  full;
    logic [CNT_WIDTH-1:0]  fifo_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [DATA_WIDTH-1:0] mq[$];
    logic [DATA_WIDTH-1:0] m_dout = '0;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .wr       (wr),
        .rd       (rd),
        .data_out (data_out),
        .empty    (empty),
        .full     (full),
        .fifo_cnt (fifo_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of stored bytes plus the last byte read out.
    always @(posedge clk) begin
        bit rd_ok;
        bit wr_ok;
        if (!rst) begin
            mq.delete();
            m_dout = '0;
        end else begin
            rd_ok = rd && (mq.size() > 0);
            wr_ok = wr && ((mq.size() < DEPTH) || rd_ok);
            if (rd_ok) m_dout = mq.pop_front();
            if (wr_ok) mq.push_back(data_in);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_cnt",   int'(fifo_cnt), mq.size());
            check("model_empty", int'(empty),    (mq.size() == 0) ? 1 : 0);
            check("model_full",  int'(full),     (mq.size() == DEPTH) ? 1 : 0);
            check("model_dout",  int'(data_out), int'(m_dout));
        end
    end

    task automatic cyc(input logic w, input logic r, input logic [DATA_WIDTH-1:0] d);
        wr      = w;
        rd      = r;
        data_in = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    initial begin
        logic [DATA_WIDTH-1:0] fill_vals[7];
        logic [DATA_WIDTH-1:0] drain_vals[8];
        fill_vals  = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd100, 8'd130};
        drain_vals = '{8'd40, 8'd50, 8'd100, 8'd130, 8'd2, 8'd3, 8'd4, 8'd5};

        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("rst_cnt",   int'(fifo_cnt), 0);
        check("rst_empty", int'(empty),    1);
        check("rst_full",  int'(full),     0);
        check("rst_dout",  int'(data_out), 0);

        cyc(1, 0, 8'd1);
        check("wr1_cnt", int'(fifo_cnt), 1);
        cyc(1, 1, 8'd2);
        check("wrrd_dout",  int'(data_out), 1);
        check("wrrd_cnt",   int'(fifo_cnt), 1);
        check("wrrd_empty", int'(empty),    0);

        for (int i = 0; i < 7; i++) cyc(1, 0, fill_vals[i]);
        check("fill_cnt",  int'(fifo_cnt), 8);
        check("fill_full", int'(full),     1);
        cyc(1, 0, 8'hFF);
        check("ovf_cnt", int'(fifo_cnt), 8);

        cyc(0, 1, 8'h00);
        check("rdfull_dout", int'(data_out), 2);
        check("rdfull_cnt",  int'(fifo_cnt), 7);
        check("rdfull_full", int'(full),     0);
        cyc(1, 0, 8'd2);
        check("refill_cnt", int'(fifo_cnt), 8);
        cyc(0, 1, 8'h00);
        check("rd10", int'(data_out), 10);
        cyc(0, 1, 8'h00);
        check("rd20",   int'(data_out), 20);
        check("rd_cnt6", int'(fifo_cnt), 6);

        cyc(1, 0, 8'd3);
        cyc(1, 0, 8'd4);
        check("full2_cnt", int'(fifo_cnt), 8);
        cyc(1, 1, 8'd5);
        check("fullwr_dout", int'(data_out), 30);
        check("fullwr_cnt",  int'(fifo_cnt), 8);

        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 8'h00);
            check("drain_dout", int'(data_out), int'(drain_vals[i]));
        end
        check("drain_empty", int'(empty),    1);
        check("drain_cnt",   int'(fifo_cnt), 0);

        cyc(0, 1, 8'h00);
        check("unf_dout", int'(data_out), 5);
        check("unf_cnt",  int'(fifo_cnt), 0);

        cyc(1, 0, 8'd7);
        cyc(1, 0, 8'd8);
        cyc(1, 0, 8'd9);
        check("pre_rst_cnt", int'(fifo_cnt), 3);
        rst = 1'b0;
        cyc(1, 1, 8'd11);
        rst = 1'b1;
        check("midrst_cnt",   int'(fifo_cnt), 0);
        check("midrst_empty", int'(empty),    1);
        check("midrst_dout",  int'(data_out), 0);

        cyc(1, 0, 8'd12);
        cyc(0, 1, 8'h00);
        check("postrst_dout", int'(data_out), 12);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, synchronous first-in-first-out buffer for byte-wide data.
- Sits between a producer and a consumer in the same clock domain.
- Accepts writes and reads on individual strobe cycles and reports empty, full and occupancy count.
- Default depth is 8 entries of 8 bits, implemented as a circular buffer with read and write pointers.

Parameters:
- DATA_WIDTH, 8, width of data_in and data_out in bits.
- DEPTH, 8, number of storage entries; must be a power of two and at least 2.
- CNT_WIDTH, 4, width of fifo_cnt; must equal clog2(DEPTH)+1 so the value DEPTH is representable.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- data_in  input  DATA_WIDTH  write data, captured on a rising edge when a write is accepted.
- wr  input  1  write strobe, level-sensitive; one write per cycle while high.
- rd  input  1  read strobe, level-sensitive; one read per cycle while high.
- data_out  output  DATA_WIDTH  registered read data.
- empty  output  1  high when fifo_cnt == 0.
- full  output  1  high when fifo_cnt == DEPTH.
- fifo_cnt  output  CNT_WIDTH  number of valid entries, 0..DEPTH.

Behaviour:
- Reset: when rst == 0 at a rising edge:
  - write pointer, read pointer and fifo_cnt are cleared to 0.
  - data_out is cleared to 0.
  - empty = 1, full = 0.
  - Storage contents are don't-care.
  - Reset overrides wr and rd in the same cycle, including mid-operation: all queued data is discarded.
- Accepted write: wr == 1 and (not full, or rd accepted in the same cycle).
  - data_in is stored at the write pointer, and the write pointer increments modulo DEPTH.
- Accepted read: rd == 1 and not empty.
  - The entry at the read pointer is loaded into data_out on that rising edge (one-cycle latency; valid immediately after the edge).
  - The read pointer increments modulo DEPTH.
- data_out holds its last value when no read is accepted.
- Count update per edge:
  - write only: +1.
  - read only: -1.
  - both accepted: unchanged.
  - neither accepted: unchanged.
- Simultaneous wr and rd:
  - When empty: only the write is performed; data_out is unchanged and count becomes 1. There is no write-through bypass.
  - When full: both the read and the write are performed and count stays DEPTH.
  - Otherwise: both are performed.
- Overflow: wr while full without rd is ignored; storage, pointers and count are unchanged.
- Underflow: rd while empty is ignored; data_out and pointers are unchanged.
- Wrap-around: pointers roll from DEPTH-1 to 0 transparently. Ordering is strict FIFO across the wrap.
- Flags empty and full are decoded combinationally from the registered count, so they reflect the state after the most recent edge.
- No reset-time assertion on X inputs. wr and rd are assumed to be driven to 0 or 1 out of reset.

Test Plan:
- Reset: hold rst=0 for 2 edges, then release -> fifo_cnt=0, empty=1, full=0, data_out=0.
- Write 1, then wr=1 with data_in=2 and rd=1 on the same edge -> data_out=1 after that edge, fifo_cnt stays 1, empty=0.
- Fill: write 10, 20, 30, 40, 50, 100, 130 on consecutive edges -> fifo_cnt=8, full=1. A further write of 0xFF is ignored and fifo_cnt stays 8.
- Read on the full FIFO -> data_out=2, fifo_cnt=7, full=0. Write 2 -> fifo_cnt=8. Two reads -> data_out=10 then 20, fifo_cnt=6.
- Full FIFO with wr=1, rd=1 on the same edge -> fifo_cnt stays 8 and the oldest value is output. Drain all entries -> values appear in write order across the pointer wrap, and empty=1 at the end.
- Read while empty -> data_out holds its previous value and fifo_cnt stays 0. Assert rst=0 with 3 entries queued -> fifo_cnt=0, empty=1, data_out=0 on the next edge.
